// File: rtl/decr_pkg.sv
// Shared FSM type, S-box tables and GF(2^8) helpers for the round decryption engine.
package decr_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StDone} fsm_state_e;

    localparam logic [63:0] SBOX0 = 64'h0123456789ABCDEF;
    localparam logic [63:0] SBOX1 = 64'h543210EDCBA9876F;
    localparam logic [63:0] SBOX2 = 64'hBA9EDC601572438F;
    localparam logic [63:0] SBOX3 = 64'hEDC01245B3A6987F;

    localparam logic [7:0] GF_RED = 8'h1B;

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_RED : 8'h00);
    endfunction

    // Multiply by a 4-bit constant c (enough for the 09/0B/0D/0E inverse-mix coefficients).
    function automatic logic [7:0] gf_mul_c(input logic [7:0] a, input logic [3:0] c);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = gf_xtime(a);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        return (c[3] ? x8 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^
               (c[1] ? x2 : 8'h00) ^ (c[0] ? a : 8'h00);
    endfunction

    function automatic logic [3:0] sbox_lookup(input logic [1:0] sel, input logic [3:0] v);
        logic [63:0] t;
        unique case (sel)
            2'd0: t = SBOX0;
            2'd1: t = SBOX1;
            2'd2: t = SBOX2;
            2'd3: t = SBOX3;
        endcase
        return t[4*v +: 4];
    endfunction

endpackage

// File: rtl/decr_round_fn.sv
// One decryption round, split at the column mix: steps 1-3 drive mix_out, steps 4-5 consume mix_in.
module decr_round_fn
    import decr_pkg::*;
(
    input  logic [31:0]  state_in,
    input  logic [255:0] key,
    input  logic [3:0]   r,
    output logic [31:0]  mix_out,
    input  logic [31:0]  mix_in,
    output logic [31:0]  state_out
);

    logic [3:0][7:0] a;
    logic [3:0][7:0] b;
    logic [7:0][3:0] n;
    logic [7:0][3:0] s;
    logic [2:0]      rot;

    // (r mod 8)+1 wrapped to 3 bits: a rotation by 8 becomes 0, i.e. no rotation.
    assign rot = r[2:0] + 3'd1;

    always_comb begin
        for (int j = 0; j < 4; j++) begin
            logic [7:0]  w;
            logic [15:0] d;
            w = state_in[8*j +: 8] ^ key[224 + 8*j - 8*int'(r) +: 8];
            d = {w, w} >> rot;
            a[j] = d[7:0];
        end
    end

    assign mix_out[7:0]   = gf_mul_c(a[0], 4'hE) ^ gf_mul_c(a[1], 4'hB) ^
                            gf_mul_c(a[2], 4'hD) ^ gf_mul_c(a[3], 4'h9);
    assign mix_out[15:8]  = gf_mul_c(a[0], 4'h9) ^ gf_mul_c(a[1], 4'hE) ^
                            gf_mul_c(a[2], 4'hB) ^ gf_mul_c(a[3], 4'hD);
    assign mix_out[23:16] = gf_mul_c(a[0], 4'hD) ^ gf_mul_c(a[1], 4'h9) ^
                            gf_mul_c(a[2], 4'hE) ^ gf_mul_c(a[3], 4'hB);
    assign mix_out[31:24] = gf_mul_c(a[0], 4'hB) ^ gf_mul_c(a[1], 4'hD) ^
                            gf_mul_c(a[2], 4'h9) ^ gf_mul_c(a[3], 4'hE);

    assign b = mix_in;
    assign n = {b[1], b[0], b[3], b[2]};

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            s[k] = sbox_lookup({key[8*(int'(r) + 2*k) + 1], key[8*(int'(r) + 2*k)]}, n[k]);
        end
    end

    // Byte j of the key window is key[8r+8j +: 8], matching {s(2j+1), s(2j)}.
    assign state_out = s ^ key[8*int'(r) +: 32];

endmodule

// File: rtl/decr_round_engine.sv
// Iterative block decryption engine; define DECR_MIX_REG_EN to register the column mix (2 cycles/round).
module decr_round_engine
    import decr_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic [255:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         busy,
    output logic [3:0]   round_idx
);

    localparam logic [3:0] LAST_R = 4'(NUM_ROUNDS - 1);

    fsm_state_e   fsm_q;
    logic [31:0]  data_q;
    logic [255:0] key_q;
    logic [3:0]   r_q;
    logic         out_valid_q;

    logic [31:0]  mix_comb;
    logic [31:0]  mix_sel;
    logic [31:0]  round_out;
    logic         round_commit;

`ifdef DECR_MIX_REG_EN
    logic [31:0]  mix_q;
    logic         phase_b_q;
    assign mix_sel      = mix_q;
    assign round_commit = phase_b_q;
`else
    assign mix_sel      = mix_comb;
    assign round_commit = 1'b1;
`endif

    decr_round_fn u_round_fn (
        .state_in  (data_q),
        .key       (key_q),
        .r         (r_q),
        .mix_out   (mix_comb),
        .mix_in    (mix_sel),
        .state_out (round_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= StIdle;
            data_q      <= '0;
            key_q       <= '0;
            r_q         <= '0;
            out_valid_q <= 1'b0;
`ifdef DECR_MIX_REG_EN
            mix_q       <= '0;
            phase_b_q   <= 1'b0;
`endif
        end else begin
            unique case (fsm_q)
                StIdle: begin
                    if (in_valid) begin
                        data_q <= in_data;
                        key_q  <= key;
                        r_q    <= LAST_R;
                        fsm_q  <= StRun;
                    end
                end
                StRun: begin
`ifdef DECR_MIX_REG_EN
                    phase_b_q <= ~phase_b_q;
                    if (!phase_b_q) begin
                        mix_q <= mix_comb;
                    end
`endif
                    if (round_commit) begin
                        data_q <= round_out;
                        if (r_q == 4'd0) begin
                            fsm_q       <= StDone;
                            out_valid_q <= 1'b1;
                        end else begin
                            r_q <= r_q - 4'd1;
                        end
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        fsm_q       <= StIdle;
                        out_valid_q <= 1'b0;
                    end
                end
                default: fsm_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (fsm_q == StIdle);
    assign busy      = (fsm_q != StIdle);
    assign out_valid = out_valid_q;
    assign out_data  = data_q;
    assign round_idx = r_q;

endmodule

// File: doc/decr_round_engine.md
DECR_ROUND_ENGINE -- requirements
Module: decr_round_engine

Interface
REQ-001 The block SHALL have parameter NUM_ROUNDS, default 16, number of decryption rounds executed per block (legal 1..16).
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port in_valid  input  1  input block offered.
REQ-005 The block SHALL have port in_ready  output  1  engine can accept a block.
REQ-006 The block SHALL have port in_data  input  32  ciphertext; byte0 = bits 7:0 ... byte3 = bits 31:24.
REQ-007 The block SHALL have port key  input  256  round key material, sampled on acceptance.
REQ-008 The block SHALL have port out_valid  output  1  result available.
REQ-009 The block SHALL have port out_ready  input  1  consumer takes result.
REQ-010 The block SHALL have port out_data  output  32  plaintext, same byte order as in_data.
REQ-011 The block SHALL have port busy  output  1  high in RUN or DONE.
REQ-012 The block SHALL have port round_idx  output  4  round index r currently being computed, 0 when idle.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, DONE; in_ready = 1 only in IDLE.
REQ-014 Acceptance SHALL occur on an edge with IDLE and in_valid=1; the edge latches in_data into the state register, latches key, sets r = NUM_ROUNDS-1 and moves to RUN.
REQ-015 In RUN, each round SHALL replace the state with round(state, r); after round r = 0, the FSM moves to DONE, else r decrements.
REQ-016 Round step 1 SHALL be pre-whitening: byte j ^= key byte at bit offset 224+8j-8r.
REQ-017 Round step 2 SHALL rotate every byte right by (r mod 8)+1 bits, except r mod 8 = 7, which leaves the bytes unrotated.
REQ-018 Round step 3 SHALL apply an inverse column mix over GF(2^8), polynomial 0x11B: b0=0E·a0^0B·a1^0D·a2^09·a3, b1=09·a0^0E·a1^0B·a2^0D·a3, b2=0D·a0^09·a1^0E·a2^0B·a3, b3=0B·a0^0D·a1^09·a2^0E·a3.
REQ-019 Round step 4 SHALL form nibbles n0..n7 = {b2 lo, b2 hi, b3 lo, b3 hi, b0 lo, b0 hi, b1 lo, b1 hi}.
REQ-020 Each nibble nk SHALL be substituted using table sel = key bits {8(r+2k)+1, 8(r+2k)}; the result is bits 4v+3:4v of the table constant for input value v.
REQ-021 The four table constants SHALL be 0x0123456789ABCDEF, 0x543210EDCBA9876F, 0xBA9EDC601572438F and 0xEDC01245B3A6987F.
REQ-022 Round step 5 SHALL form output byte j = {s(2j+1), s(2j)} ^ key byte at bit offset 8r+8j.
REQ-023 In DONE, out_valid SHALL be 1 and out_data SHALL hold the final state stable; an edge with out_ready=1 returns the FSM to IDLE.
REQ-024 Latency from the acceptance edge to the first out_valid=1 cycle SHALL be NUM_ROUNDS cycles without the macro and 2·NUM_ROUNDS cycles with it.
REQ-025 in_valid asserted while busy SHALL be ignored, and no data SHALL be captured.
REQ-026 Changes to the key port after acceptance SHALL have no effect on the block in flight.

Reset
REQ-027 An edge with rst=1 SHALL force IDLE, r=0, and clear the state register and latched key to 0, overriding any simultaneous in_valid or out_ready.
REQ-028 Reset values SHALL be: in_ready=1 (combinational from IDLE), out_valid=0, out_data=0, busy=0, round_idx=0.
REQ-029 Reset mid-RUN or in DONE SHALL discard the block, and no out_valid SHALL follow.

Configuration
REQ-030 Macro DECR_MIX_REG_EN, when defined, SHALL insert a register after the column mix; each round then takes 2 cycles (phase A: steps 1-3, phase B: steps 4-5), and round_idx is held across both phases.
REQ-031 Without DECR_MIX_REG_EN, steps 1-5 SHALL be single-cycle combinational; results SHALL be bit-identical in both builds.

Structure
REQ-032 Package decr_pkg SHALL hold the FSM state enum, the four S-box table constants, the 0x1B reduction constant and the gf_xtime function.
REQ-033 Sub-module decr_round_fn SHALL implement steps 1-5 combinationally (inputs: state, key, r; output: next state), optionally split at the mix for DECR_MIX_REG_EN.

Verification
REQ-034 NUM_ROUNDS=1, key=0, in_data=0x00000000 -> out_data=0xFFFFFFFF, out_valid one cycle after acceptance (two cycles with macro).
REQ-035 NUM_ROUNDS=1, key=0, in_data=0x00000001 -> out_data=0x13BE0825.
REQ-036 NUM_ROUNDS=16, random key and data -> out_data matches the reference model; round_idx steps 15..0; latency 16 cycles (32 with macro).
REQ-037 Hold out_ready=0 for 5 cycles in DONE -> out_data stable and out_valid=1 throughout; in_valid pulses in that window are ignored.
REQ-038 Assert rst at round 7 of 16 -> next cycle in_ready=1, busy=0, out_data=0; a following block decrypts correctly.
REQ-039 Change key every cycle during RUN -> result equals the one computed with the key sampled at acceptance.
